// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-port arbiter in front of a single-port block RAM.
//
// Port 0 carries data-side requests, port 1 carries instruction fetches.
// At most one request is accepted per cycle and driven straight onto the
// RAM pins in the same cycle (zero wait states). Read responses come back
// exactly one cycle later, steered to the requesting port by a one-entry
// response tag (rsp_pend_q / rsp_port_q).
//
// Build option:
//   MEM_ARBITER_RR_EN  defined   -> ties are broken round-robin through a
//                                   1-bit preferred-port pointer.
//                      undefined -> fixed priority, port 0 always wins ties
//                                   and no pointer register exists.
//
// Reset is synchronous and active high. The RAM-side request path and the
// read response outputs are combinational by construction: the RAM must see
// the request in the accepting cycle, and ram_dout is only valid in the
// single cycle after the read.

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // Port 0 (data)
    input  logic              p0_valid,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ready,
    output logic              p0_rvalid,

    // Port 1 (instruction fetch)
    input  logic              p1_valid,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ready,
    output logic              p1_rvalid,

    // Shared read data, qualified by p0_rvalid / p1_rvalid
    output logic [DATA_W-1:0] rdata,

    // Block RAM port
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_di,
    input  logic [DATA_W-1:0] ram_dout
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic rsp_pend_q;   // a read was accepted last cycle
    logic rsp_pend_d;
    logic rsp_port_q;   // which port that read belongs to (0/1)
    logic rsp_port_d;

`ifdef MEM_ARBITER_RR_EN
    logic ptr_q;        // preferred port on a tie
    logic ptr_d;
`endif

    // ------------------------------------------------------------------
    // Arbitration signals
    // ------------------------------------------------------------------
    logic prefer1_s;    // 1 when port 1 wins a tie this cycle
    logic grant0_s;
    logic grant1_s;
    logic acc_we_s;     // type of the accepted request
    logic acc_rd_s;     // a read was accepted this cycle

    // Tie preference: pointer in round-robin builds, port 0 otherwise.
`ifdef MEM_ARBITER_RR_EN
    assign prefer1_s = ptr_q;
`else
    assign prefer1_s = 1'b0;
`endif

    // Pick at most one winner; nothing is accepted while in reset.
    always_comb begin
        grant0_s = 1'b0;
        grant1_s = 1'b0;
        if (rst) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (p0_valid && p1_valid) begin
            grant0_s = ~prefer1_s;
            grant1_s = prefer1_s;
        end else begin
            grant0_s = p0_valid;
            grant1_s = p1_valid;
        end
    end

    // Steer the winning request onto the RAM pins in the same cycle.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        acc_we_s = 1'b0;
        if (grant1_s) begin
            ram_en   = 1'b1;
            ram_we   = p1_we;
            ram_addr = p1_addr;
            ram_di   = p1_wdata;
            acc_we_s = p1_we;
        end else if (grant0_s) begin
            ram_en   = 1'b1;
            ram_we   = p0_we;
            ram_addr = p0_addr;
            ram_di   = p0_wdata;
            acc_we_s = p0_we;
        end else begin
            ram_en   = 1'b0;
            ram_we   = 1'b0;
            ram_addr = '0;
            ram_di   = '0;
            acc_we_s = 1'b0;
        end
    end

    assign p0_ready = grant0_s;
    assign p1_ready = grant1_s;
    assign acc_rd_s = (grant0_s || grant1_s) && !acc_we_s;

    // Next-state for the response tag: tag every accepted read, writes leave nothing behind.
    always_comb begin
        rsp_pend_d = acc_rd_s;
        rsp_port_d = rsp_port_q;
        if (acc_rd_s) begin
            rsp_port_d = grant1_s;
        end else begin
            rsp_port_d = rsp_port_q;
        end
    end

`ifdef MEM_ARBITER_RR_EN
    // Next-state for the tie pointer: after any acceptance, prefer the other port.
    always_comb begin
        ptr_d = ptr_q;
        if (grant0_s) begin
            ptr_d = 1'b1;
        end else if (grant1_s) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end
`endif

    // State registers; reset clears any in-flight read so it is never answered.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_pend_q <= 1'b0;
            rsp_port_q <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            ptr_q      <= 1'b0;
`endif
        end else begin
            rsp_pend_q <= rsp_pend_d;
            rsp_port_q <= rsp_port_d;
`ifdef MEM_ARBITER_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    // Read response: RAM output is valid only in the cycle after the read,
    // so it is forwarded directly. Reset masks a read tagged on the edge
    // just before reset was raised.
    always_comb begin
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        rdata     = '0;
        if (rst) begin
            p0_rvalid = 1'b0;
            p1_rvalid = 1'b0;
            rdata     = '0;
        end else if (rsp_pend_q) begin
            p0_rvalid = ~rsp_port_q;
            p1_rvalid = rsp_port_q;
            rdata     = ram_dout;
        end else begin
            p0_rvalid = 1'b0;
            p1_rvalid = 1'b0;
            rdata     = '0;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter -- self-checking bench for mem_arbiter.
// Contains a behavioural block RAM and a transaction-level reference model
// (winner selection, memory contents, one outstanding read) that predicts
// every arbiter output each cycle. Follows MEM_ARBITER_RR_EN like the RTL.

module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          p0_valid, p0_we, p1_valid, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ready, p1_ready, p0_rvalid, p1_rvalid;
    logic [DW-1:0] rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_di;
    logic [DW-1:0] ram_dout;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ready(p0_ready), .p0_rvalid(p0_rvalid),
        .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ready(p1_ready), .p1_rvalid(p1_rvalid),
        .rdata(rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
        .ram_dout(ram_dout)
    );

    // Behavioural block RAM (256 words) with a bench-side clear/preload path.
    logic          ram_clr;
    logic          pre_en;
    logic [7:0]    pre_addr;
    logic [DW-1:0] pre_data;
    logic [DW-1:0] ram_mem [0:255];

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= '0;
            ram_dout <= '0;
        end else if (pre_en) begin
            ram_mem[pre_addr] <= pre_data;
        end else if (ram_en) begin
            if (ram_we) ram_mem[ram_addr[7:0]] <= ram_di;
            else        ram_dout <= ram_mem[ram_addr[7:0]];
        end
    end

    // Reference model state.
    logic [DW-1:0] m_mem [0:255];
    logic          m_pend;
    logic          m_pend_port;
    logic [DW-1:0] m_pend_data;
    logic          m_ptr;

    // Snapshot of outputs from the last cycle, for scenario-specific checks.
    logic          s_p0_ready, s_p1_ready, s_rv0, s_rv1, s_ram_en, s_ram_we;
    logic [DW-1:0] s_rdata;
    logic          acc0, acc1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, what, obs, exp);
        end
    endtask

    // One clock cycle: inputs are already driven; check at negedge, advance model.
    task automatic cycle(input string tag);
        int            win;
        logic          w_we;
        logic [AW-1:0] w_addr;
        logic [DW-1:0] w_data;
        @(negedge clk);
        s_p0_ready = p0_ready; s_p1_ready = p1_ready;
        s_rv0 = p0_rvalid; s_rv1 = p1_rvalid; s_rdata = rdata;
        s_ram_en = ram_en; s_ram_we = ram_we;

        // Responses owed from the previous cycle.
        if (rst) begin
            chk(tag, "p0_rvalid", p0_rvalid, 0);
            chk(tag, "p1_rvalid", p1_rvalid, 0);
            chk(tag, "rdata", rdata, 0);
        end else begin
            chk(tag, "p0_rvalid", p0_rvalid, m_pend && !m_pend_port);
            chk(tag, "p1_rvalid", p1_rvalid, m_pend && m_pend_port);
            if (m_pend) chk(tag, "rdata", rdata, m_pend_data);
        end

        // Who should win this cycle.
        win = -1;
        if (!rst) begin
            if (p0_valid && p1_valid) begin
`ifdef MEM_ARBITER_RR_EN
                win = m_ptr ? 1 : 0;
`else
                win = 0;
`endif
            end else if (p0_valid) win = 0;
            else if (p1_valid)     win = 1;
        end
        w_we   = (win == 1) ? p1_we    : p0_we;
        w_addr = (win == 1) ? p1_addr  : p0_addr;
        w_data = (win == 1) ? p1_wdata : p0_wdata;

        chk(tag, "p0_ready", p0_ready, win == 0);
        chk(tag, "p1_ready", p1_ready, win == 1);
        chk(tag, "ram_en", ram_en, win >= 0);
        chk(tag, "ram_we", ram_we, (win >= 0) && w_we);
        if (win >= 0) begin
            chk(tag, "ram_addr", ram_addr, w_addr);
            chk(tag, "ram_di", ram_di, w_data);
        end
        acc0 = (win == 0);
        acc1 = (win == 1);

        // Advance the model across the coming edge.
        if (rst) begin
            m_pend = 1'b0;
            m_ptr  = 1'b0;
        end else begin
            m_pend = (win >= 0) && !w_we;
            if (m_pend) begin
                m_pend_port = (win == 1);
                m_pend_data = m_mem[w_addr[7:0]];
            end
            if ((win >= 0) && w_we) m_mem[w_addr[7:0]] = w_data;
            if (win == 0) m_ptr = 1'b1;
            else if (win == 1) m_ptr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_ports();
        p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        idle_ports();
        repeat (n) cycle("reset");
        rst = 1'b0;
    endtask

    // Load one RAM word (only while in reset, so the arbiter drives no RAM traffic).
    task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        m_mem[a] = d;
        cycle("preload");
        pre_en = 1'b0;
    endtask

    logic          r_act  [2];
    logic          r_we   [2];
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_data [2];

    initial begin
        rst = 1'b1; ram_clr = 1'b1; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
        idle_ports();
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        m_pend = 1'b0; m_pend_port = 1'b0; m_pend_data = '0; m_ptr = 1'b0;
        @(posedge clk); #1;
        ram_clr = 1'b0;

        // Reset state, with requests present: nothing may be accepted.
        p0_valid = 1'b1; p1_valid = 1'b1;
        cycle("reset_state");
        chk("reset_state", "ram_en", s_ram_en, 0);
        preload(8'd47, 32'd1);
        preload(8'd147, 32'd1256);
        preload(8'd46, 32'd777);
        do_reset(1);

        // Write then read the same address on port 0.
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'd55; p0_wdata = 32'd23;
        cycle("wr55");
        chk("wr55", "ready", s_p0_ready, 1);
        p0_we = 1'b0; p0_wdata = 32'd0;
        cycle("rd55");
        chk("rd55", "ready", s_p0_ready, 1);
        idle_ports();
        cycle("rd55_rsp");
        chk("rd55_rsp", "rvalid", s_rv0, 1);
        chk("rd55_rsp", "rdata", s_rdata, 32'd23);

        // Four cycles of contention, first cycle right after reset release.
        do_reset(1);
        p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'd47;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'd147;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) idle_ports();
            cycle("tie");
`ifdef MEM_ARBITER_RR_EN
            if (k < 4) chk("tie", "p0_first", s_p0_ready, (k % 2) == 0);
            if (k >= 1) begin
                chk("tie", "rv0_alt", s_rv0, (k % 2) == 1);
                chk("tie", "rdata_alt", s_rdata, ((k % 2) == 1) ? 32'd1 : 32'd1256);
            end
`else
            if (k < 4) chk("tie", "p0_always", s_p0_ready, 1);
            chk("tie", "p1_starved", s_p1_ready, 0);
            chk("tie", "p1_rv_never", s_rv1, 0);
            if (k >= 1) chk("tie", "rdata_p0", s_rdata, 32'd1);
`endif
        end

        // Read accepted just before reset is squashed.
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'd147;
        cycle("squash_acc");
        chk("squash_acc", "ready", s_p1_ready, 1);
        rst = 1'b1; idle_ports();
        for (int k = 0; k < 2; k++) begin
            cycle("squash_rst");
            chk("squash_rst", "rv1", s_rv1, 0);
            chk("squash_rst", "ram_en", s_ram_en, 0);
        end
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle("squash_after");
            chk("squash_after", "rv1", s_rv1, 0);
        end

        // Simultaneous write (p0) and read (p1), pointer at port 0.
        do_reset(1);
        p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'd147; p0_wdata = 32'd2;
        p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'd46;
        cycle("wr_rd_1");
        chk("wr_rd_1", "p0_ready", s_p0_ready, 1);
        chk("wr_rd_1", "ram_we", s_ram_we, 1);
        p0_valid = 1'b0; p0_we = 1'b0;
        cycle("wr_rd_2");
        chk("wr_rd_2", "p1_ready", s_p1_ready, 1);
        chk("wr_rd_2", "no_wr_rv", s_rv0, 0);
        idle_ports();
        cycle("wr_rd_3");
        chk("wr_rd_3", "rv1", s_rv1, 1);
        chk("wr_rd_3", "rdata", s_rdata, 32'd777);

        // Randomised traffic with occasional resets, held requests until ready.
        do_reset(1);
        for (int p = 0; p < 2; p++) begin
            r_act[p] = 1'b0; r_we[p] = 1'b0; r_addr[p] = '0; r_data[p] = '0;
        end
        for (int n = 0; n < 600; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!r_act[p] && ($urandom_range(0, 99) < 65)) begin
                    r_act[p]  = 1'b1;
                    r_we[p]   = ($urandom_range(0, 2) == 0);
                    r_addr[p] = AW'($urandom_range(0, 15));
                    r_data[p] = $urandom;
                end
            end
            rst = ($urandom_range(0, 49) == 0);
            p0_valid = r_act[0]; p0_we = r_we[0]; p0_addr = r_addr[0]; p0_wdata = r_data[0];
            p1_valid = r_act[1]; p1_we = r_we[1]; p1_addr = r_addr[1]; p1_wdata = r_data[1];
            cycle("rand");
            if (acc0) r_act[0] = 1'b0;
            if (acc1) r_act[1] = 1'b0;
        end
        rst = 1'b0;
        idle_ports();
        repeat (2) cycle("drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the address width of both requester ports and the RAM port.
REQ-002 Parameter DATA_W, default 32, SHALL set the write-data and read-data width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the synchronous, active-high reset, sampled on the rising clk edge.
REQ-005 p0_valid / p1_valid  input  1  SHALL be the request valid from port 0 (data) and port 1 (instruction fetch).
REQ-006 p0_we / p1_we  input  1  SHALL be the request type: 1 = write, 0 = read.
REQ-007 p0_addr / p1_addr  input  ADDR_W  SHALL be the request word address.
REQ-008 p0_wdata / p1_wdata  input  DATA_W  SHALL be the write data, ignored for reads.
REQ-009 p0_ready / p1_ready  output  1  SHALL signal acceptance of that port's request this cycle (combinational).
REQ-010 p0_rvalid / p1_rvalid  output  1  SHALL pulse for one cycle when that port's read data is valid.
REQ-011 rdata  output  DATA_W  SHALL carry the read data, shared by both ports, qualified by p0_rvalid/p1_rvalid.
REQ-012 ram_en, ram_we  output  1, ram_addr  output  ADDR_W, ram_di  output  DATA_W  SHALL drive the block RAM's en, we, addr and di.
REQ-013 ram_dout  input  DATA_W  SHALL be the block RAM read data, valid one cycle after an enabled read.

Function
REQ-014 At most one request SHALL be accepted per cycle; accepted = pN_valid && pN_ready.
REQ-015 In the accepting cycle, ram_en=1, and ram_we/ram_addr/ram_di SHALL equal the accepted port's we/addr/wdata (combinational path); with no acceptance, ram_en=0 and ram_we=0.
REQ-016 A requester SHALL hold valid, we, addr and wdata stable until ready; the arbiter SHALL not depend on early deassertion.
REQ-017 When only one port is valid, that port SHALL be accepted in the same cycle (zero-wait, back-to-back every cycle allowed).
REQ-018 When both are valid, the winner SHALL be chosen per REQ-027/REQ-028; the loser's ready SHALL be 0.
REQ-019 A response-tag register (rsp_pend, rsp_port) SHALL capture each accepted read; in the following cycle, exactly the tagged port's rvalid=1 and rdata=ram_dout.
REQ-020 Writes SHALL produce no rvalid; a write is complete in its accepting cycle.
REQ-021 Read latency SHALL be exactly 1 cycle from acceptance to rvalid, including back-to-back reads alternating ports.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the written data.
REQ-023 Both rvalid outputs SHALL never be 1 in the same cycle.

Reset
REQ-024 While rst=1: p0_ready=p1_ready=0, ram_en=0, ram_we=0, p0_rvalid=p1_rvalid=0, rdata=0, rsp_pend=0, priority pointer=port 0.
REQ-025 A read accepted in the cycle before rst asserts SHALL be squashed: no rvalid in any cycle while rst=1 or after release.
REQ-026 The first cycle after rst deasserts SHALL accept requests normally, port 0 winning a tie.

Configuration
REQ-027 With macro MEM_ARBITER_RR_EN defined, ties SHALL be broken round-robin: a 1-bit pointer names the preferred port, resets to 0, and after any acceptance points to the port not accepted.
REQ-028 Without MEM_ARBITER_RR_EN, port 0 SHALL always win ties (fixed priority), no pointer register is instantiated, and port 1 can be starved.

Verification
REQ-029 p0 write addr=55 data=23, then p0 read addr=55 next cycle -> p0_ready=1 both cycles, p0_rvalid=1 with rdata=23 one cycle after read accept.
REQ-030 Both valid for 4 cycles (p0 read 47, p1 read 147, RAM preloaded 1/1256), RR_EN defined -> accept order p0,p1,p0,p1; rvalid alternates p0/p1 with rdata 1/1256, one cycle lagged.
REQ-031 Same stimulus, RR_EN undefined -> p0 accepted all 4 cycles, p1_ready=0 throughout, p1_rvalid never 1.
REQ-032 p1 read addr=147 accepted, rst=1 on next edge -> p1_rvalid=0 during and after reset, ram_en=0 while rst=1.
REQ-033 p0 write addr=147 data=2 simultaneous with p1 read addr=46, RR_EN defined, pointer=0 -> write accepted first (ram_we=1), read next cycle; no rvalid for the write, p1_rvalid one cycle after its accept.
